// File: rtl/wb_trace_buffer_pkg.sv
// wb_trace_buffer_pkg
//   Shared constants and helpers for the writeback trace buffer.
//   RV_NOP / RV_EBREAK are the canonical RV32I encodings. is_bubble() flags the
//   encodings that carry no architectural work: an all-zero slot and the
//   canonical nop (addi x0, x0, 0).
package wb_trace_buffer_pkg;

  localparam logic [31:0] RV_ZERO   = 32'h00000000;
  localparam logic [31:0] RV_NOP    = 32'h00000013;
  localparam logic [31:0] RV_EBREAK = 32'h00100073;

  function automatic logic is_bubble(input logic [31:0] inst);
    return (inst == RV_ZERO) || (inst == RV_NOP);
  endfunction

endpackage

// File: rtl/wb_trace_buffer_trace_fifo.sv
// wb_trace_buffer_trace_fifo
//   Circular first-word-fall-through FIFO holding trace entries.
//   Ports:
//     clk      in   rising-edge clock
//     reset    in   asynchronous active-high reset (pointers only)
//     i_push   in   write i_wdata at the tail
//     i_wdata  in   entry to write
//     i_pop    in   consume the head entry
//     o_rdata  out  head entry (combinational from storage)
//     o_valid  out  at least one entry held
//     o_full   out  DEPTH entries held
//     o_count  out  occupied entries, 0..DEPTH
//   A push while full is only taken when a pop happens in the same cycle; the
//   written slot is the one the pop vacates.
module wb_trace_buffer_trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_valid,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_pop;
  logic w_push;

  assign o_valid = (r_wr_ptr != r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  assign w_pop  = i_pop & o_valid;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer
//   Retirement trace buffer on the CPU writeback stream. Captures each real
//   instruction with a sequence tag into a circular FIFO, stops after the halt
//   instruction, and drains through a ready/valid read port.
//   Ports:
//     clk       in   rising-edge clock
//     reset     in   asynchronous active-high reset
//     go        in   capture enable
//     wb_inst   in   instruction in WB this cycle
//     rd_ready  in   consumer takes the head entry
//     rd_valid  out  head entry available
//     rd_inst   out  head instruction, 0 when empty
//     rd_seq    out  head sequence tag, 0 when empty
//     count     out  occupied entries
//     drop_cnt  out  captures lost to a full buffer (saturating)
//     overflow  out  sticky: at least one drop
//     halted    out  sticky: HALT_INST captured
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned SEQ_W        = 16,
  parameter int unsigned SKIP_BUBBLES = 1,
  parameter logic [31:0] HALT_INST    = RV_EBREAK
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  input  logic [31:0]            wb_inst,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [31:0]            rd_inst,
  output logic [SEQ_W-1:0]       rd_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            drop_cnt,
  output logic                   overflow,
  output logic                   halted
);

  localparam int unsigned        WIDTH   = 32 + SEQ_W;
  localparam logic [SEQ_W-1:0]   SEQ_ONE = 1;

  logic [SEQ_W-1:0] r_seq_next;
  logic [15:0]      r_drop_cnt;
  logic             r_overflow;
  logic             r_halted;

  logic             w_bubble;
  logic             w_cap;
  logic             w_pop;
  logic             w_full;
  logic             w_valid;
  logic             w_store;
  logic             w_drop;
  logic [WIDTH-1:0] w_rdata;

  assign w_bubble = (SKIP_BUBBLES != 0) && is_bubble(wb_inst);
  assign w_cap    = go & ~r_halted & ~w_bubble;
  assign w_pop    = w_valid & rd_ready;
  assign w_store  = w_cap & (~w_full | w_pop);
  assign w_drop   = w_cap & w_full & ~w_pop;

  wb_trace_buffer_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_store),
    .i_wdata ({wb_inst, r_seq_next}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_valid (w_valid),
    .o_full  (w_full),
    .o_count (count)
  );

  // Every capture consumes a tag, stored or not, so drops show as tag gaps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seq_next <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      if (w_cap) r_seq_next <= r_seq_next + SEQ_ONE;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_cap && (wb_inst == HALT_INST)) r_halted <= 1'b1;
    end
  end

  assign rd_valid = w_valid;
  assign rd_inst  = w_valid ? w_rdata[WIDTH-1 -: 32] : 32'h0;
  assign rd_seq   = w_valid ? w_rdata[SEQ_W-1:0] : '0;
  assign drop_cnt = r_drop_cnt;
  assign overflow = r_overflow;
  assign halted   = r_halted;

endmodule
